// File: rtl/jtag_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, IR capture pattern and the
// TAP next-state function used by jtag_tap.
package jtag_pkg;

  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SHF_DR = 4'h2,
    PAU_DR = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SHF_IR = 4'hA,
    PAU_IR = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_t;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TLR;
    case (s)
      TLR:    n = tms ? TLR    : RTI;
      RTI:    n = tms ? SEL_DR : RTI;
      SEL_DR: n = tms ? SEL_IR : CAP_DR;
      CAP_DR: n = tms ? EX1_DR : SHF_DR;
      SHF_DR: n = tms ? EX1_DR : SHF_DR;
      EX1_DR: n = tms ? UPD_DR : PAU_DR;
      PAU_DR: n = tms ? EX2_DR : PAU_DR;
      EX2_DR: n = tms ? UPD_DR : SHF_DR;
      UPD_DR: n = tms ? SEL_DR : RTI;
      SEL_IR: n = tms ? TLR    : CAP_IR;
      CAP_IR: n = tms ? EX1_IR : SHF_IR;
      SHF_IR: n = tms ? EX1_IR : SHF_IR;
      EX1_IR: n = tms ? UPD_IR : PAU_IR;
      PAU_IR: n = tms ? EX2_IR : PAU_IR;
      EX2_IR: n = tms ? UPD_IR : SHF_IR;
      UPD_IR: n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Two-flop synchronizer for one asynchronous bit, plus single-clk rise/fall
// pulses derived from a registered copy of the synchronized value.
module jtag_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/jtag_tap.sv
// Target-side JTAG TAP: oversampled 1149.1 controller with an IR and a byte
// data path to RX/TX FIFOs. Define JTAG_TAP_BYPASS_EN for the all-ones bypass DR.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH = 10,
  parameter int DR_WIDTH = 8,
  parameter logic [IR_WIDTH-1:0] IR_RESET = {IR_WIDTH{1'b1}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir,
  output logic                ir_update,
  output logic [DR_WIDTH-1:0] rx_data,
  output logic                rx_wr,
  input  logic                rx_full,
  input  logic [DR_WIDTH-1:0] tx_data,
  output logic                tx_rd,
  input  logic                tx_empty,
  output logic                overflow,
  output logic                underflow
);

  localparam int CNT_W = $clog2(DR_WIDTH + 1);

  logic tck_s, tck_rise, tck_fall;
  logic tms_s, tms_rise, tms_fall;
  logic tdi_s, tdi_rise, tdi_fall;

  jtag_sync_edge u_sync_tck (
    .clk  (clk),
    .rst  (rst),
    .din  (tck),
    .sync (tck_s),
    .rise (tck_rise),
    .fall (tck_fall)
  );

  jtag_sync_edge u_sync_tms (
    .clk  (clk),
    .rst  (rst),
    .din  (tms),
    .sync (tms_s),
    .rise (tms_rise),
    .fall (tms_fall)
  );

  jtag_sync_edge u_sync_tdi (
    .clk  (clk),
    .rst  (rst),
    .din  (tdi),
    .sync (tdi_s),
    .rise (tdi_rise),
    .fall (tdi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{tck_s, tms_rise, tms_fall, tdi_rise, tdi_fall};

  tap_state_t          state;
  tap_state_t          next_state;
  logic [IR_WIDTH-1:0] ir_sh;
  logic [DR_WIDTH-1:0] dr_sh;
  logic [DR_WIDTH-1:0] dr_next;
  logic [DR_WIDTH-1:0] tx_word;
  logic [CNT_W-1:0]    dr_cnt;
  logic                byp;
  logic                bypass;
  logic                byte_done;

`ifdef JTAG_TAP_BYPASS_EN
  assign bypass = &ir;
`else
  assign bypass = 1'b0;
`endif

  assign next_state = tap_next(state, tms_s);
  assign tap_state  = state;
  assign dr_next    = {tdi_s, dr_sh[DR_WIDTH-1:1]};
  assign tx_word    = tx_empty ? '0 : tx_data;
  assign byte_done  = (dr_cnt == CNT_W'(DR_WIDTH - 1));

  // Handshake: rx_wr and tx_rd are single-clk strobes issued on the tck_rise
  // update; rx_full / tx_empty / tx_data are sampled in that same clk, so a
  // first-word-fall-through TX FIFO pops its head on the cycle after tx_rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TLR;
      ir        <= IR_RESET;
      ir_sh     <= '0;
      dr_sh     <= '0;
      dr_cnt    <= '0;
      byp       <= 1'b0;
      tdo       <= 1'b0;
      ir_update <= 1'b0;
      rx_data   <= '0;
      rx_wr     <= 1'b0;
      tx_rd     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      ir_update <= 1'b0;
      rx_wr     <= 1'b0;
      tx_rd     <= 1'b0;

      if (tck_rise) begin
        state <= next_state;
        if (next_state == TLR) begin
          overflow  <= 1'b0;
          underflow <= 1'b0;
        end
        // Actions are keyed on the state being left, not the one entered.
        case (state)
          TLR: begin
            ir     <= IR_RESET;
            dr_cnt <= '0;
          end
          CAP_IR: ir_sh <= IR_WIDTH'(IR_CAPTURE);
          SHF_IR: ir_sh <= {tdi_s, ir_sh[IR_WIDTH-1:1]};
          UPD_IR: begin
            ir        <= ir_sh;
            ir_update <= 1'b1;
          end
          CAP_DR: begin
            if (bypass) begin
              byp <= 1'b0;
            end else begin
              dr_sh  <= tx_word;
              dr_cnt <= '0;
              if (tx_empty) underflow <= 1'b1;
              else          tx_rd     <= 1'b1;
            end
          end
          SHF_DR: begin
            if (bypass) begin
              byp <= tdi_s;
            end else if (byte_done) begin
              rx_data <= dr_next;
              if (rx_full) overflow <= 1'b1;
              else         rx_wr    <= 1'b1;
              dr_sh  <= tx_word;
              dr_cnt <= '0;
              if (tx_empty) underflow <= 1'b1;
              else          tx_rd     <= 1'b1;
            end else begin
              dr_sh  <= dr_next;
              dr_cnt <= dr_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end

      if (tck_fall) begin
        case (state)
          SHF_IR:  tdo <= ir_sh[0];
          SHF_DR:  tdo <= bypass ? byp : dr_sh[0];
          default: tdo <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap.sv
// Directed bench for jtag_tap: bit-banged TAP sequences, a small FWFT TX FIFO
// model and an RX capture queue checked against hand-computed bytes.
module tb_jtag_tap;

  localparam int IR_WIDTH = 10;
  localparam int DR_WIDTH = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                tck = 1'b0;
  logic                tms = 1'b0;
  logic                tdi = 1'b0;
  logic                tdo;
  logic [3:0]          tap_state;
  logic [IR_WIDTH-1:0] ir;
  logic                ir_update;
  logic [DR_WIDTH-1:0] rx_data;
  logic                rx_wr;
  logic                rx_full = 1'b0;
  logic [DR_WIDTH-1:0] tx_data;
  logic                tx_rd;
  logic                tx_empty;
  logic                overflow;
  logic                underflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jtag_tap #(
    .IR_WIDTH (IR_WIDTH),
    .DR_WIDTH (DR_WIDTH),
    .IR_RESET (10'h3FF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .tap_state (tap_state),
    .ir        (ir),
    .ir_update (ir_update),
    .rx_data   (rx_data),
    .rx_wr     (rx_wr),
    .rx_full   (rx_full),
    .tx_data   (tx_data),
    .tx_rd     (tx_rd),
    .tx_empty  (tx_empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // TX FIFO model (first-word-fall-through) and strobe monitors
  logic [7:0] tx_mem [16];
  int         tx_wr_idx = 0;
  int         tx_rd_idx = 0;
  int         n_tx_rd   = 0;
  int         n_ir_upd  = 0;
  logic [7:0] rx_got [$];
  logic [7:0] exp_q [$];

  assign tx_data  = tx_mem[tx_rd_idx[3:0]];
  assign tx_empty = (tx_rd_idx == tx_wr_idx);

  always @(posedge clk) begin
    if (rx_wr) rx_got.push_back(rx_data);
    if (tx_rd) begin
      n_tx_rd   <= n_tx_rd + 1;
      tx_rd_idx <= tx_rd_idx + 1;
    end
    if (ir_update) n_ir_upd <= n_ir_upd + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tx_push(input logic [7:0] b);
    tx_mem[tx_wr_idx[3:0]] = b;
    tx_wr_idx++;
  endtask

  // One tck period (5 clk low, 5 clk high); tdo sampled just before the rise.
  task automatic tck_cycle(input logic t_ms, input logic t_di, output logic t_do);
    tms = t_ms;
    tdi = t_di;
    repeat (5) @(negedge clk);
    t_do = tdo;
    tck = 1'b1;
    repeat (5) @(negedge clk);
    tck = 1'b0;
  endtask

  task automatic tms_step(input logic t_ms);
    logic d;
    tck_cycle(t_ms, 1'b0, d);
  endtask

  task automatic shift_bits(input int n, input logic [31:0] din, input logic last_tms,
                            output logic [31:0] dout);
    logic b;
    dout = '0;
    for (int i = 0; i < n; i++) begin
      tck_cycle((i == n - 1) ? last_tms : 1'b0, din[i], b);
      dout[i] = b;
    end
  endtask

  // From RTI: full IR scan back to RTI.
  task automatic ir_scan(input logic [IR_WIDTH-1:0] val, output logic [31:0] dout);
    tms_step(1'b1);
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    shift_bits(IR_WIDTH, 32'(val), 1'b1, dout);
    tms_step(1'b1);
    tms_step(1'b0);
  endtask

  // From RTI: n-bit DR scan back to RTI.
  task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    shift_bits(n, din, 1'b1, dout);
    tms_step(1'b1);
    tms_step(1'b0);
  endtask

  task automatic check_rx(input string tag, input int base);
    logic [7:0] e;
    logic [7:0] g;
    int         idx;
    idx = base;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (idx < rx_got.size()) ? rx_got[idx] : 8'hxx;
      check_eq(tag, 32'(g), 32'(e));
      idx++;
    end
  endtask

  initial begin
    logic [31:0] dout;
    int          rx_base;
    int          tx_base;
    int          upd_base;

    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_state", 32'(tap_state), 32'hF);
    check_eq("rst_ir", 32'(ir), 32'h3FF);
    check_eq("rst_tdo", 32'(tdo), 32'h0);
    check_eq("rst_strobes", {29'd0, ir_update, rx_wr, tx_rd}, 32'h0);
    check_eq("rst_flags", {30'd0, overflow, underflow}, 32'h0);
    check_eq("rst_rx_data", 32'(rx_data), 32'h0);

    // IR scan of 0x2A5
    upd_base = n_ir_upd;
    tms_step(1'b0);
    check_eq("rti_state", 32'(tap_state), 32'hC);
    ir_scan(10'h2A5, dout);
    check_eq("ir_value", 32'(ir), 32'h2A5);
    check_eq("ir_update_cnt", 32'(n_ir_upd - upd_base), 32'd1);
    check_eq("ir_tdo", dout, 32'h001);
    check_eq("ir_end_state", 32'(tap_state), 32'hC);

    // 32-bit DR scan against four TX bytes
    tx_push(8'h11); tx_push(8'h22); tx_push(8'h33); tx_push(8'h44);
    rx_base = rx_got.size();
    tx_base = n_tx_rd;
    dr_scan(32, 32'h00FF5AA5, dout);
    check_eq("dr32_rx_cnt", 32'(rx_got.size() - rx_base), 32'd4);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    check_rx("dr32_rx_byte", rx_base);
    check_eq("dr32_tx_rd_cnt", 32'(n_tx_rd - tx_base), 32'd4);
    check_eq("dr32_tdo", dout, 32'h44332211);
    check_eq("dr32_underflow", 32'(underflow), 32'h1);
    check_eq("dr32_overflow", 32'(overflow), 32'h0);

    // From SHF_DR, five tms=1 clocks reach TLR and clear flags
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    check_eq("shf_dr_state", 32'(tap_state), 32'h2);
    for (int i = 0; i < 5; i++) tms_step(1'b1);
    check_eq("tlr_state", 32'(tap_state), 32'hF);
    check_eq("tlr_flags", {30'd0, overflow, underflow}, 32'h0);
    tms_step(1'b0);
    check_eq("tlr_ir_reset", 32'(ir), 32'h3FF);
    ir_scan(10'h001, dout);
    check_eq("ir2_tdo", dout, 32'h001);
    check_eq("ir2_value", 32'(ir), 32'h001);

    // Overflow: RX full during an 8-bit scan
    tx_push(8'h3C);
    rx_full = 1'b1;
    rx_base = rx_got.size();
    tx_base = n_tx_rd;
    dr_scan(8, 32'h96, dout);
    rx_full = 1'b0;
    check_eq("ovf_rx_cnt", 32'(rx_got.size() - rx_base), 32'd0);
    check_eq("ovf_flag", 32'(overflow), 32'h1);
    check_eq("ovf_tdo", dout, 32'h3C);
    check_eq("ovf_tx_rd_cnt", 32'(n_tx_rd - tx_base), 32'd1);
    check_eq("ovf_underflow", 32'(underflow), 32'h1);

    // Partial byte is dropped
    rx_base = rx_got.size();
    dr_scan(5, 32'h15, dout);
    check_eq("part_rx_cnt", 32'(rx_got.size() - rx_base), 32'd0);
    check_eq("part_tdo", dout, 32'h0);

    // Pause in the middle of a byte
    tx_push(8'hC3);
    rx_base = rx_got.size();
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    shift_bits(4, 32'hB, 1'b1, dout);
    check_eq("pause_tdo_lo", dout, 32'h3);
    tms_step(1'b0);
    for (int i = 0; i < 10; i++) tms_step(1'b0);
    check_eq("pause_state", 32'(tap_state), 32'h3);
    tms_step(1'b1);
    tms_step(1'b0);
    shift_bits(4, 32'h6, 1'b1, dout);
    check_eq("pause_tdo_hi", dout, 32'hC);
    tms_step(1'b1);
    tms_step(1'b0);
    check_eq("pause_rx_cnt", 32'(rx_got.size() - rx_base), 32'd1);
    exp_q.push_back(8'h6B);
    check_rx("pause_rx_byte", rx_base);

`ifdef JTAG_TAP_BYPASS_EN
    // Bypass: all-ones IR, tdo is tdi delayed one tck with a leading 0
    ir_scan(10'h3FF, dout);
    check_eq("byp_ir", 32'(ir), 32'h3FF);
    tx_push(8'h77);
    rx_base = rx_got.size();
    tx_base = n_tx_rd;
    dr_scan(4, 32'hB, dout);
    check_eq("byp_tdo", dout, 32'h6);
    check_eq("byp_rx_cnt", 32'(rx_got.size() - rx_base), 32'd0);
    check_eq("byp_tx_rd_cnt", 32'(n_tx_rd - tx_base), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
